sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller. One request per idle cycle, fixed strobe
// timing with a programmable access stretch. The pad buffer registers both
// directions, so reads spend an extra capture cycle before the result lands.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus released, ready for a request
// RD_ACC   | CE/OE asserted, WAIT_CYCLES+1 cycles of access time
// RD_CAP   | strobes held one more cycle while the pad register catches up
// WR_SETUP | data driven onto the pads, CE asserted, WE still high
// WR_PULSE | WE low for WAIT_CYCLES+1 cycles
// WR_HOLD  | WE released, data still driven for hold time
// TURN     | bus turnaround, pads released, done pulses
module sram_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              tristate_output_enable,
    output logic [DATA_W-1:0] Data_write,
    input  logic [DATA_W-1:0] Data_read
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, RD_ACC, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, TURN
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rd_done_q, rd_done_d;
    logic       accept;

    // State, wait counter and read-complete flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_done_q <= rd_done_d;
        end
    end

    // Request capture and read-result register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            SRAM_ADDR  <= '0;
            Data_write <= '0;
            rdata      <= '0;
        end else begin
            if (accept) begin
                SRAM_ADDR <= addr;
            end
            if (accept && we) begin
                Data_write <= wdata;
            end
            if (state_q == RD_CAP) begin
                rdata <= Data_read;
            end
        end
    end

    // Next-state and strobe decode; the counter is reloaded on every transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        rd_done_d = 1'b0;
        ready     = 1'b0;
        accept    = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        tristate_output_enable = 1'b0;
        done      = rd_done_q || (state_q == TURN);

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept  = 1'b1;
                    state_d = we ? WR_SETUP : RD_ACC;
                    cnt_d   = we ? 3'd0 : WAIT_LD;
                end
            end
            RD_ACC: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                if (cnt_q == 3'd0) begin
                    state_d = RD_CAP;
                    cnt_d   = 3'd0;
                end
            end
            RD_CAP: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                state_d   = IDLE;
                cnt_d     = 3'd0;
                rd_done_d = 1'b1;
            end
            WR_SETUP: begin
                SRAM_CE_N = 1'b0;
                tristate_output_enable = 1'b1;
                state_d   = WR_PULSE;
                cnt_d     = WAIT_LD;
            end
            WR_PULSE: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                tristate_output_enable = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = WR_HOLD;
                    cnt_d   = 3'd0;
                end
            end
            WR_HOLD: begin
                SRAM_CE_N = 1'b0;
                tristate_output_enable = 1'b1;
                state_d   = TURN;
                cnt_d     = 3'd0;
            end
            TURN: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 0, 1, 7), each with a
// registered pad buffer + SRAM model and a cycle-timeline reference model.
module tb_sram_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    logic        req   [3];
    logic        we    [3];
    logic [19:0] addr  [3];
    logic [15:0] wdata [3];
    logic        ready [3];
    logic        done  [3];
    logic [15:0] rdata [3];
    logic [19:0] sram_addr [3];
    logic        ce_n  [3];
    logic        oe_n  [3];
    logic        we_n  [3];
    logic        ten   [3];
    logic [15:0] data_write [3];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input logic [19:0] a);
        if (a == 20'h00012) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", nm, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 7);

        logic [15:0] dr_q = '0;
        logic [15:0] pad_q = '0;
        logic        pad_en_q = 1'b0;
        logic [15:0] pin;
        logic [15:0] smem [int];
        logic [15:0] rmem [int];

        bit          busy = 1'b0;
        bit          rd = 1'b0;
        int          phase = 0;
        logic [19:0] e_addr = '0;
        logic [15:0] e_wdata = '0;
        logic [15:0] e_rdata = '0;

        sram_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(W)) u_dut (
            .Clk(Clk), .Reset(Reset),
            .req(req[g]), .we(we[g]), .addr(addr[g]), .wdata(wdata[g]),
            .ready(ready[g]), .done(done[g]), .rdata(rdata[g]),
            .SRAM_ADDR(sram_addr[g]), .SRAM_CE_N(ce_n[g]), .SRAM_OE_N(oe_n[g]),
            .SRAM_WE_N(we_n[g]), .tristate_output_enable(ten[g]),
            .Data_write(data_write[g]), .Data_read(dr_q)
        );

        // Pad buffer (one register each way) and the SRAM array behind it
        always @(posedge Clk) begin
            if (pad_en_q) pin = pad_q;
            else if (!ce_n[g] && !oe_n[g])
                pin = smem.exists(int'(sram_addr[g])) ? smem[int'(sram_addr[g])] : init_val(sram_addr[g]);
            else pin = 16'hFFFF;
            if (!ce_n[g] && !we_n[g] && pad_en_q) smem[int'(sram_addr[g])] = pad_q;
            dr_q     <= pin;
            pad_q    <= data_write[g];
            pad_en_q <= ten[g];
        end

        // Reference timeline: phase counts cycles since the acceptance edge
        always @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                busy = 1'b0; rd = 1'b0; phase = 0; e_rdata = '0;
            end else begin
                bit idle_like;
                idle_like = !busy || (rd && phase == W + 3);
                if (req[g] && idle_like) begin
                    busy = 1'b1; phase = 1; rd = !we[g]; e_addr = addr[g];
                    if (we[g]) e_wdata = wdata[g];
                end else if (busy) begin
                    phase++;
                    if (!rd && phase == W + 4) rmem[int'(e_addr)] = e_wdata;
                    if ((rd && phase > W + 3) || (!rd && phase > W + 4)) busy = 1'b0;
                end
                if (busy && rd && phase == W + 3)
                    e_rdata = rmem.exists(int'(e_addr)) ? rmem[int'(e_addr)] : init_val(e_addr);
            end
        end

        // Per-cycle compare against the reference timeline
        always @(negedge Clk) begin
            if (chk_en) begin
                bit il, wr, rda, ce_on;
                il    = !busy || (rd && phase == W + 3);
                wr    = busy && !rd;
                rda   = busy && rd && phase <= W + 2;
                ce_on = rda || (wr && phase <= W + 3);
                chk("ready", g, 32'(ready[g]), 32'(il));
                chk("done", g, 32'(done[g]), 32'(busy && ((rd && phase == W + 3) || (!rd && phase == W + 4))));
                chk("ce_n", g, 32'(ce_n[g]), 32'(!ce_on));
                chk("oe_n", g, 32'(oe_n[g]), 32'(!rda));
                chk("we_n", g, 32'(we_n[g]), 32'(!(wr && phase >= 2 && phase <= W + 2)));
                chk("t_en", g, 32'(ten[g]), 32'(wr && phase <= W + 3));
                chk("rdata", g, 32'(rdata[g]), 32'(e_rdata));
                if (ce_on) chk("sram_addr", g, 32'(sram_addr[g]), 32'(e_addr));
                if (wr && phase <= W + 3) chk("data_write", g, 32'(data_write[g]), 32'(e_wdata));
            end
        end
    end

    task automatic xact(input int i, input logic w, input logic [19:0] a, input logic [15:0] d,
                        output int lat, output int oel, output int wel, output int enh);
        int n;
        lat = 0; oel = 0; wel = 0; enh = 0;
        @(negedge Clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        n = 0;
        while (ready[i] !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        @(posedge Clk);
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge Clk);
            req[i] = 1'b0;
            if (ce_n[i] === 1'b0 && oe_n[i] === 1'b0) oel++;
            if (we_n[i] === 1'b0) wel++;
            if (ten[i] === 1'b1) enh++;
            if (done[i] === 1'b1) lat = c;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int lat, oel, wel, enh, acc, dn, n;
        logic w;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_ready", 1, 32'(ready[1]), 32'd1);
        chk("rst_strobes", 1, {29'd0, ce_n[1], oe_n[1], we_n[1]}, 32'd7);
        chk("rst_ten", 1, 32'(ten[1]), 32'd0);
        chk("rst_done", 1, 32'(done[1]), 32'd0);
        chk("rst_rdata", 1, 32'(rdata[1]), 32'd0);
        chk("rst_addr", 1, 32'(sram_addr[1]), 32'd0);
        chk("rst_dwrite", 1, 32'(data_write[1]), 32'd0);
        chk_en = 1'b1;

        xact(1, 1'b0, 20'h00012, 16'h0000, lat, oel, wel, enh);
        chk("rd_lat_w1", 1, 32'(lat), 32'd4);
        chk("rd_oe_low_w1", 1, 32'(oel), 32'd3);
        chk("rd_beef", 1, 32'(rdata[1]), 32'hBEEF);

        xact(1, 1'b1, 20'h00034, 16'hA5A5, lat, oel, wel, enh);
        chk("wr_lat_w1", 1, 32'(lat), 32'd5);
        chk("wr_we_low_w1", 1, 32'(wel), 32'd2);
        chk("wr_ten_high_w1", 1, 32'(enh), 32'd4);
        chk("wr_oe_low_w1", 1, 32'(oel), 32'd0);

        xact(1, 1'b0, 20'h00034, 16'h0000, lat, oel, wel, enh);
        chk("wr_rd_lat", 1, 32'(lat), 32'd4);
        chk("wr_rd_data", 1, 32'(rdata[1]), 32'hA5A5);

        acc = 0; dn = 0; w = 1'b0;
        for (int c = 0; c < 200 && acc < 6; c++) begin
            @(negedge Clk);
            if (done[1] === 1'b1) dn++;
            if (ready[1] === 1'b1) begin
                we[1] = w; addr[1] = 20'h00100 + 20'(acc); wdata[1] = 16'h1000 + 16'(acc);
                acc++;
                w = !w;
            end
            req[1] = 1'b1;
        end
        for (int c = 0; c < 40 && dn < 6; c++) begin
            @(negedge Clk);
            req[1] = 1'b0;
            if (done[1] === 1'b1) dn++;
        end
        req[1] = 1'b0;
        chk("b2b_accepts", 1, 32'(acc), 32'd6);
        chk("b2b_dones", 1, 32'(dn), 32'd6);

        repeat (2) @(negedge Clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 20'h00077; wdata[1] = 16'h7777;
        n = 0;
        while (ready[1] !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        @(posedge Clk);
        @(negedge Clk);
        req[1] = 1'b0;
        @(negedge Clk);
        chk("pulse_we_n", 1, 32'(we_n[1]), 32'd0);
        #1 Reset = 1'b1;
        #1;
        chk("abort_strobes", 1, {29'd0, ce_n[1], oe_n[1], we_n[1]}, 32'd7);
        chk("abort_ten", 1, 32'(ten[1]), 32'd0);
        chk("abort_done", 1, 32'(done[1]), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("abort_ready", 1, 32'(ready[1]), 32'd1);
        repeat (4) @(negedge Clk);

        xact(0, 1'b0, 20'h00012, 16'h0000, lat, oel, wel, enh);
        chk("rd_lat_w0", 0, 32'(lat), 32'd3);
        chk("rd_beef_w0", 0, 32'(rdata[0]), 32'hBEEF);
        xact(0, 1'b1, 20'h00055, 16'h1234, lat, oel, wel, enh);
        chk("wr_lat_w0", 0, 32'(lat), 32'd4);
        chk("wr_we_low_w0", 0, 32'(wel), 32'd1);
        xact(0, 1'b0, 20'h00055, 16'h0000, lat, oel, wel, enh);
        chk("wr_rd_w0", 0, 32'(rdata[0]), 32'h1234);

        xact(2, 1'b0, 20'h00040, 16'h0000, lat, oel, wel, enh);
        chk("rd_lat_w7", 2, 32'(lat), 32'd10);
        chk("rd_oe_low_w7", 2, 32'(oel), 32'd9);
        chk("rd_val_w7", 2, 32'(rdata[2]), 32'h5A1A);
        xact(2, 1'b1, 20'h00040, 16'hC3C3, lat, oel, wel, enh);
        chk("wr_lat_w7", 2, 32'(lat), 32'd11);
        chk("wr_we_low_w7", 2, 32'(wel), 32'd8);
        xact(2, 1'b0, 20'h00040, 16'h0000, lat, oel, wel, enh);
        chk("wr_rd_w7", 2, 32'(rdata[2]), 32'hC3C3);

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
